sr_instr_encoder: RTL

//  Inverse of the schoolRISCV control decoder: turns abstract op requests (op, rd, rs1, rs2, imm)

---
 rtl/sr_instr_encoder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sr_instr_encoder.sv
// -----------------------------------------------------------------------------
// sr_instr_encoder
//   Inverse of the schoolRISCV control decoder. Turns abstract op requests
//   (op, rd, rs1, rs2, imm) into 32-bit RV32I/P-subset instruction words.
//   Legal words are tagged with a word address and queued in a small FIFO that
//   feeds an instruction-memory loader. Illegal requests are accepted, dropped
//   and counted.
//
// Ports
//   clk, rst            clock / asynchronous active-high reset
//   restart             synchronous clear: flush FIFO, rewind address, clear errors
//   req_valid/req_ready request handshake
//   req_op              0 ADD,1 OR,2 SRL,3 SLTU,4 SUB,5 KSLL8,6 KSLLI8,7 ADDI,
//                       8 LUI,9 BEQ,10 BNE (11..15 illegal)
//   req_rd/rs1/rs2      register fields
//   req_imm             immediate / branch byte offset, two's complement
//   out_valid/out_ready FIFO head handshake
//   out_instr/out_addr  encoded word at FIFO head and its word address
//   err_sticky          set by any dropped request
//   err_count           saturating dropped-request count
// -----------------------------------------------------------------------------
module sr_instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] baseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  fifoDepth = CNT_W'(DEPTH);

  localparam logic [6:0] opcR   = 7'b0110011;
  localparam logic [6:0] opcP   = 7'b1110111;
  localparam logic [6:0] opcI   = 7'b0010011;
  localparam logic [6:0] opcLui = 7'b0110111;
  localparam logic [6:0] opcB   = 7'b1100011;

  localparam logic signed [31:0] addiMin   = -32'sd2048;
  localparam logic signed [31:0] addiMax   = 32'sd2047;
  localparam logic signed [31:0] branchMin = -32'sd4096;
  localparam logic signed [31:0] branchMax = 32'sd4094;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_OR     = 4'd1,
    OP_SRL    = 4'd2,
    OP_SLTU   = 4'd3,
    OP_SUB    = 4'd4,
    OP_KSLL8  = 4'd5,
    OP_KSLLI8 = 4'd6,
    OP_ADDI   = 4'd7,
    OP_LUI    = 4'd8,
    OP_BEQ    = 4'd9,
    OP_BNE    = 4'd10
  } opKind_e;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  opKind_e            reqOp;
  logic signed [31:0] immS;
  logic [31:0]        encWord;
  logic               encLegal;

  assign reqOp = opKind_e'(req_op);
  assign immS  = $signed(req_imm);

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    encWord  = '0;
    encLegal = 1'b0;
    case (reqOp)
      OP_ADD: begin
        encWord  = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, opcR};
        encLegal = 1'b1;
      end
      OP_OR: begin
        encWord  = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, opcR};
        encLegal = 1'b1;
      end
      OP_SRL: begin
        encWord  = {7'b0000000, req_rs2, req_rs1, 3'b101, req_rd, opcR};
        encLegal = 1'b1;
      end
      OP_SLTU: begin
        encWord  = {7'b0000000, req_rs2, req_rs1, 3'b011, req_rd, opcR};
        encLegal = 1'b1;
      end
      OP_SUB: begin
        encWord  = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, opcR};
        encLegal = 1'b1;
      end
      OP_KSLL8: begin
        encWord  = {7'b0110110, req_rs2, req_rs1, 3'b000, req_rd, opcP};
        encLegal = 1'b1;
      end
      OP_KSLLI8: begin
        // Shift amount lives in the rs2 slot as {2'b01, imm[2:0]}.
        encWord  = {7'b0111110, 2'b01, req_imm[2:0], req_rs1, 3'b000, req_rd, opcP};
        encLegal = (req_imm < 32'd8);
      end
      OP_ADDI: begin
        encWord  = {req_imm[11:0], req_rs1, 3'b000, req_rd, opcI};
        encLegal = (immS >= addiMin) && (immS <= addiMax);
      end
      OP_LUI: begin
        encWord  = {req_imm[31:12], req_rd, opcLui};
        encLegal = (req_imm[11:0] == 12'h000);
      end
      OP_BEQ, OP_BNE: begin
        encWord  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                    2'b00, (reqOp == OP_BNE), req_imm[4:1], req_imm[11], opcB};
        encLegal = !req_imm[0] && (immS >= branchMin) && (immS <= branchMax);
      end
      default: begin
        encWord  = '0;
        encLegal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]       memInstr [DEPTH];
  logic [ADDR_W-1:0] memAddr  [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic [ADDR_W-1:0] addrCnt;

  logic accept;
  logic push;
  logic drop;
  logic pop;

  // Full FIFO refuses requests even when the head is popping this cycle.
  assign req_ready = !restart && (fifoCount < fifoDepth);
  assign accept    = req_valid && req_ready;
  assign push      = accept && encLegal;
  assign drop      = accept && !encLegal;
  assign out_valid = (fifoCount != '0);
  assign pop       = out_valid && out_ready;

  // Empty FIFO shows a zero word and the next address to be issued.
  assign out_instr = out_valid ? memInstr[rdPtr] : '0;
  assign out_addr  = out_valid ? memAddr[rdPtr]  : addrCnt;

  // NOTE: the storage array carries no reset; fifoCount gates every read, so
  // stale contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      memInstr[wrPtr] <= encWord;
      memAddr[wrPtr]  <= addrCnt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifoCount  <= '0;
      addrCnt    <= baseAddr;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (restart) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifoCount  <= '0;
      addrCnt    <= baseAddr;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + 1'b1;
        addrCnt <= addrCnt + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      if (drop) begin
        err_sticky <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
